// File: rtl/dmem_dump_reader.sv
// Halts the core, sweeps a word-aligned window of data memory and streams each word out on valid/ready.
// Optional running checksum of the dumped words: define DMEM_DUMP_CHECKSUM_EN.
module dmem_dump_reader #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int STRIDE   = 4,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        count,
  output logic              core_en,
  output logic [ADDR_W-1:0] address_line,
  output logic              wr,
  input  logic [DATA_W-1:0] data_out,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int LAT_W = $clog2(READ_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic              core_en_reg, core_en_next;
  logic [ADDR_W-1:0] address_reg;
  logic [7:0]        remaining_reg;
  logic [LAT_W-1:0]  lat_cnt_reg;
  logic [DATA_W-1:0] dump_data_reg;
  logic [ADDR_W-1:0] dump_addr_reg;
  logic              start_accept;
  logic              handshake;
  logic              last_wait;

  assign start_accept = (state_reg == S_IDLE) && start;
  assign handshake    = (state_reg == S_PRESENT) && dump_ready;
  assign last_wait    = (state_reg == S_WAIT) && (lat_cnt_reg == LAT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = (count == 8'd0) ? S_DONE : S_HALT;
        end
      end
      S_HALT:  state_next = S_WAIT;
      S_WAIT: begin
        if (lat_cnt_reg == LAT_W'(1)) begin
          state_next = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (dump_ready) begin
          state_next = (remaining_reg == 8'd1) ? S_DONE : S_WAIT;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The core runs whenever we are idle; a zero-length request never halts it.
  assign core_en_next = (state_next == S_IDLE) ||
                        ((state_reg == S_IDLE) && (state_next == S_DONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_en_reg   <= 1'b0;
      address_reg   <= '0;
      remaining_reg <= '0;
      lat_cnt_reg   <= '0;
      dump_data_reg <= '0;
      dump_addr_reg <= '0;
    end else begin
      core_en_reg <= core_en_next;
      if (start_accept && (count != 8'd0)) begin
        address_reg   <= base_addr;
        remaining_reg <= count;
      end
      if (state_reg == S_HALT) begin
        lat_cnt_reg <= LAT_LOAD;
      end
      if (state_reg == S_WAIT) begin
        lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
      end
      if (last_wait) begin
        dump_data_reg <= data_out;
        dump_addr_reg <= address_reg;
      end
      // Address wraps modulo 2^ADDR_W by construction.
      if (handshake) begin
        remaining_reg <= remaining_reg - 8'd1;
        if (remaining_reg != 8'd1) begin
          address_reg <= address_reg + ADDR_W'(STRIDE);
          lat_cnt_reg <= LAT_LOAD;
        end
      end
    end
  end

`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_reg <= '0;
    end else if (start_accept) begin
      checksum_reg <= '0;
    end else if (handshake) begin
      checksum_reg <= checksum_reg + dump_data_reg;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif

  assign core_en      = core_en_reg;
  assign address_line = address_reg;
  assign wr           = 1'b0;
  assign dump_valid   = (state_reg == S_PRESENT);
  assign dump_data    = dump_data_reg;
  assign dump_addr    = dump_addr_reg;
  assign busy         = (state_reg == S_HALT) || (state_reg == S_WAIT) || (state_reg == S_PRESENT);
  assign done         = (state_reg == S_DONE);

endmodule
